// File: rtl/toycpu_bus_pkg.sv
// Shared definitions for the toycpu memory bus.
// Holds the default address/data widths and the arbiter FSM state encoding.
// The processor bus logic uses the same encoding.
package toycpu_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } bus_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req   in  2  request lines, bit N = requester N
//   last  in  1  index of the requester served most recently
//   pick  out 1  index of the chosen requester (meaningful only when valid)
//   valid out 1  at least one requester is asking
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);

    always_comb begin
        valid = |req;
        // On a tie the requester that was not served last wins.
        if (req == 2'b11) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the toycpu 256x16 unified memory between requester 0
// (CPU bus) and requester 1 (program loader / debug DMA).
// Grants alternate fairly between the two requesters. A requester holding
// mN_lock keeps the bus for up to MAX_BURST back-to-back accesses.
//   clk, rst_n                     clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata      requester N access request (N = 0, 1)
//   mN_gnt/ack/rdata               requester N grant, completion pulse, read data
//   mem_addr/wdata/we              memory bus (write on posedge clk)
//   mem_rdata                      memory combinational read data
module mem_arbiter
    import toycpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = toycpu_bus_pkg::BUS_ADDR_W,
    parameter int unsigned DATA_W    = toycpu_bus_pkg::BUS_DATA_W,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned         CNT_W      = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]    BURST_LAST = CNT_W'(MAX_BURST - 1);

    bus_state_t       state;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             pick;
    logic             pick_valid;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Grants are registered alongside the state so every bus output is
    // qualified by a flop that the asynchronous reset clears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (pick_valid) begin
                        state  <= pick ? ST_OWN1 : ST_OWN0;
                        gnt0_q <= ~pick;
                        gnt1_q <= pick;
                    end
                end
                ST_OWN0: begin
                    if (m0_req && m0_lock && (burst_cnt < BURST_LAST)) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end else begin
                        state     <= ST_IDLE;
                        last      <= 1'b0;
                        burst_cnt <= '0;
                        gnt0_q    <= 1'b0;
                    end
                end
                ST_OWN1: begin
                    if (m1_req && m1_lock && (burst_cnt < BURST_LAST)) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end else begin
                        state     <= ST_IDLE;
                        last      <= 1'b1;
                        burst_cnt <= '0;
                        gnt1_q    <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        m0_gnt    = gnt0_q;
        m1_gnt    = gnt1_q;
        m0_ack    = gnt0_q & m0_req;
        m1_ack    = gnt1_q & m1_req;
        m0_rdata  = m0_ack ? mem_rdata : '0;
        m1_rdata  = m1_ack ? mem_rdata : '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt0_q) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_req & m0_we;
        end else if (gnt1_q) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_req & m1_we;
        end
    end

endmodule
